// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory path.
//   mem_req_t  : one downstream request beat {addr, we, wdata, be, id}
//   mem_rtrn_t : one downstream return beat {id, data}
//   id encoding: {src, tid}, src 0 = I$, 1 = D$
package wt_cache_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned RTRN_W = 128;
  localparam int unsigned TID_W  = 2;
  localparam int unsigned ID_W   = TID_W + 1;

  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_DCACHE = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   id;
  } mem_req_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RTRN_W-1:0] data;
  } mem_rtrn_t;

endpackage

// File: rtl/wt_mem_arbiter.sv
// Merges I$ and D$ write-through request streams onto one memory port,
// tracks outstanding transactions per source and routes returns back.
// Widths come from wt_cache_pkg; MAX_OUT bounds outstanding txns per source.
//   icache_* / dcache_*     : request in (held until ack), combinational ack out
//   mem_req_*               : registered downstream request, valid/ready
//   mem_rtrn_*              : downstream return (no backpressure)
//   *_rtrn_vld/tid, rtrn_data_o : registered returns, one cycle after mem_rtrn
//   idle_o, err_o           : registered status, err_o sticky until reset
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              icache_data_req_i,
  output logic              icache_data_ack_o,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic [TID_W-1:0]  icache_tid_i,
  input  logic              dcache_data_req_i,
  output logic              dcache_data_ack_o,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic              dcache_we_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  input  logic [BE_W-1:0]   dcache_be_i,
  input  logic [TID_W-1:0]  dcache_tid_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_we_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [BE_W-1:0]   mem_req_be_o,
  output logic [ID_W-1:0]   mem_req_id_o,
  input  logic              mem_rtrn_valid_i,
  input  logic [ID_W-1:0]   mem_rtrn_id_i,
  input  logic [RTRN_W-1:0] mem_rtrn_data_i,
  output logic              icache_rtrn_vld_o,
  output logic [TID_W-1:0]  icache_rtrn_tid_o,
  output logic              dcache_rtrn_vld_o,
  output logic [TID_W-1:0]  dcache_rtrn_tid_o,
  output logic [RTRN_W-1:0] rtrn_data_o,
  output logic              idle_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  out_state_e state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       prio_q, prio_d;   // source favoured on the next contention
  mem_rtrn_t  rtrn;

  logic       can_load, drain;
  logic [1:0] elig, gnt_vec, rtrn_hit, below_max, cnt_zero, busy_d;

  assign rtrn     = {mem_rtrn_id_i, mem_rtrn_data_i};
  assign drain    = (state_q == OUT_FULL) & mem_req_ready_i;
  // register can take a new request when empty or emptying this cycle
  assign can_load = (state_q == OUT_EMPTY) | mem_req_ready_i;

  assign elig[0] = icache_data_req_i & below_max[0];
  assign elig[1] = dcache_data_req_i & below_max[1];

  assign rtrn_hit[0] = mem_rtrn_valid_i & (rtrn.id[TID_W] == SRC_ICACHE);
  assign rtrn_hit[1] = mem_rtrn_valid_i & (rtrn.id[TID_W] == SRC_DCACHE);

  // 2-way round robin: lone eligible source wins, otherwise the favoured one
  always_comb begin
    gnt_vec = 2'b00;
    if (can_load) begin
      if (elig[0] & (~elig[1] | (prio_q == SRC_ICACHE))) gnt_vec[0] = 1'b1;
      else if (elig[1])                                  gnt_vec[1] = 1'b1;
    end
  end

  assign icache_data_ack_o = gnt_vec[0];
  assign dcache_data_ack_o = gnt_vec[1];

  // Outstanding counters; a return against an empty counter is not counted
  for (genvar g = 0; g < 2; g++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc = gnt_vec[g];
    assign dec = rtrn_hit[g] & (cnt_q != '0);

    always_comb begin
      cnt_d = cnt_q;
      if (inc & ~dec)      cnt_d = cnt_q + CNT_W'(1);
      else if (dec & ~inc) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign below_max[g] = cnt_q < CNT_W'(MAX_OUT);
    assign cnt_zero[g]  = (cnt_q == '0);
    assign busy_d[g]    = (cnt_d != '0);
  end

  // Output register next state: load on grant, empty on drain without grant
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    prio_d  = prio_q;
    if (gnt_vec[0]) begin
      state_d     = OUT_FULL;
      req_d.addr  = icache_addr_i;
      req_d.we    = 1'b0;
      req_d.wdata = '0;
      req_d.be    = '1;
      req_d.id    = {SRC_ICACHE, icache_tid_i};
      prio_d      = SRC_DCACHE;
    end else if (gnt_vec[1]) begin
      state_d     = OUT_FULL;
      req_d.addr  = dcache_addr_i;
      req_d.we    = dcache_we_i;
      req_d.wdata = dcache_wdata_i;
      req_d.be    = dcache_be_i;
      req_d.id    = {SRC_DCACHE, dcache_tid_i};
      prio_d      = SRC_ICACHE;
    end else if (drain) begin
      state_d     = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OUT_EMPTY;
      req_q   <= '0;
      prio_q  <= SRC_ICACHE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      prio_q  <= prio_d;
    end
  end

  assign mem_req_valid_o = (state_q == OUT_FULL);
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_we_o    = req_q.we;
  assign mem_req_wdata_o = req_q.wdata;
  assign mem_req_be_o    = req_q.be;
  assign mem_req_id_o    = req_q.id;

  // Return routing and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icache_rtrn_vld_o <= 1'b0;
      dcache_rtrn_vld_o <= 1'b0;
      icache_rtrn_tid_o <= '0;
      dcache_rtrn_tid_o <= '0;
      rtrn_data_o       <= '0;
      idle_o            <= 1'b1;
      err_o             <= 1'b0;
    end else begin
      icache_rtrn_vld_o <= rtrn_hit[0];
      dcache_rtrn_vld_o <= rtrn_hit[1];
      if (rtrn_hit[0])      icache_rtrn_tid_o <= rtrn.id[TID_W-1:0];
      if (rtrn_hit[1])      dcache_rtrn_tid_o <= rtrn.id[TID_W-1:0];
      if (mem_rtrn_valid_i) rtrn_data_o       <= rtrn.data;
      idle_o <= ~busy_d[0] & ~busy_d[1] & (state_d == OUT_EMPTY);
      err_o  <= err_o | (rtrn_hit[0] & cnt_zero[0]) | (rtrn_hit[1] & cnt_zero[1]);
    end
  end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Testbench for wt_mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic against a queue-based model of outstanding txns.
module tb_wt_mem_arbiter;

  localparam int MAX_OUT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, ready = 1'b1, rvalid = 1'b0;
  logic [63:0]  iaddr = '0, daddr = '0, dwdata = '0;
  logic [1:0]   itid = '0, dtid = '0;
  logic [7:0]   dbe = '0;
  logic [2:0]   rid = '0;
  logic [127:0] rdata = '0;

  logic         iack, dack, mvalid, mwe, ivld, dvld, idle, err;
  logic [63:0]  maddr, mwdata;
  logic [7:0]   mbe;
  logic [2:0]   mid;
  logic [1:0]   itid_o, dtid_o;
  logic [127:0] rdata_o;

  wt_mem_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .icache_data_req_i(ireq), .icache_data_ack_o(iack),
    .icache_addr_i(iaddr), .icache_tid_i(itid),
    .dcache_data_req_i(dreq), .dcache_data_ack_o(dack),
    .dcache_addr_i(daddr), .dcache_we_i(dwe), .dcache_wdata_i(dwdata),
    .dcache_be_i(dbe), .dcache_tid_i(dtid),
    .mem_req_valid_o(mvalid), .mem_req_ready_i(ready),
    .mem_req_addr_o(maddr), .mem_req_we_o(mwe), .mem_req_wdata_o(mwdata),
    .mem_req_be_o(mbe), .mem_req_id_o(mid),
    .mem_rtrn_valid_i(rvalid), .mem_rtrn_id_i(rid), .mem_rtrn_data_i(rdata),
    .icache_rtrn_vld_o(ivld), .icache_rtrn_tid_o(itid_o),
    .dcache_rtrn_vld_o(dvld), .dcache_rtrn_tid_o(dtid_o),
    .rtrn_data_o(rdata_o), .idle_o(idle), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding transactions are lists of TIDs per source; the downstream
  // register is one optional slot; m_prio=1 means D$ wins the next tie.
  bit           m_valid, m_we, m_prio, m_ivld, m_dvld, m_err, m_gnt_i, m_gnt_d;
  logic [63:0]  m_addr, m_wdata;
  logic [7:0]   m_be;
  logic [2:0]   m_id;
  logic [1:0]   m_itid, m_dtid;
  logic [127:0] m_data;
  logic [1:0]   q_i[$];
  logic [1:0]   q_d[$];

  function automatic void exp_grants(output bit gi, output bit gd);
    bit room, wi, wd;
    room = !m_valid || ready;
    wi   = ireq && (q_i.size() < MAX_OUT);
    wd   = dreq && (q_d.size() < MAX_OUT);
    gi   = room && wi && (!wd || !m_prio);
    gd   = room && wd && !gi;
  endfunction

  function automatic int find_tid(input logic [1:0] q[$], input logic [1:0] t);
    foreach (q[k]) if (q[k] == t) return k;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit gi, gd;
    if (!rst_n) begin
      m_valid = 0; m_we = 0; m_prio = 0; m_ivld = 0; m_dvld = 0; m_err = 0;
      m_gnt_i = 0; m_gnt_d = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_id = '0;
      m_itid = '0; m_dtid = '0; m_data = '0;
      q_i.delete(); q_d.delete();
    end else begin
      exp_grants(gi, gd);
      m_gnt_i = gi; m_gnt_d = gd;
      m_ivld = 0; m_dvld = 0;
      if (rvalid) begin
        m_data = rdata;
        if (rid[2]) begin
          m_dvld = 1; m_dtid = rid[1:0];
          if (q_d.size() == 0) m_err = 1;
          else q_d.delete(find_tid(q_d, rid[1:0]));
        end else begin
          m_ivld = 1; m_itid = rid[1:0];
          if (q_i.size() == 0) m_err = 1;
          else q_i.delete(find_tid(q_i, rid[1:0]));
        end
      end
      if (gi) begin
        q_i.push_back(itid);
        m_valid = 1; m_addr = iaddr; m_we = 0; m_wdata = '0; m_be = 8'hFF;
        m_id = {1'b0, itid}; m_prio = 1;
      end else if (gd) begin
        q_d.push_back(dtid);
        m_valid = 1; m_addr = daddr; m_we = dwe; m_wdata = dwdata; m_be = dbe;
        m_id = {1'b1, dtid}; m_prio = 0;
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit gi, gd;
    if (rst_n && chk_en) begin
      exp_grants(gi, gd);
      chk("ack_i", iack, gi);
      chk("ack_d", dack, gd);
      chk("req_valid", mvalid, m_valid);
      if (m_valid) begin
        chk("req_addr", maddr, m_addr);
        chk("req_we", mwe, m_we);
        chk("req_wdata", mwdata, m_wdata);
        chk("req_be", mbe, m_be);
        chk("req_id", mid, m_id);
      end
      chk("ivld", ivld, m_ivld);
      if (m_ivld) chk("itid", itid_o, m_itid);
      chk("dvld", dvld, m_dvld);
      if (m_dvld) chk("dtid", dtid_o, m_dtid);
      if (m_ivld || m_dvld) chk("rdata", rdata_o, m_data);
      chk("idle", idle, (q_i.size() == 0) && (q_d.size() == 0) && !m_valid);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("rst_valid", mvalid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_data", rdata_o, 128'h0);
    chk_en = 1'b1;

    // single I$ read
    tick(); ireq = 1; iaddr = 64'h8000_0000; itid = 2'd1;
    #2 chk("a_ack", iack, 1'b1);
    tick(); ireq = 0;
    #2 chk("a_valid", mvalid, 1'b1);
    chk("a_id", mid, 3'b001);
    chk("a_be", mbe, 8'hFF);
    chk("a_addr", maddr, 64'h8000_0000);
    chk("a_wdata", mwdata, 64'h0);
    tick(); rvalid = 1; rid = 3'b001; rdata = 128'h5;
    #2 chk("a_drained", mvalid, 1'b0);
    tick(); rvalid = 0;
    #2 chk("a_ivld", ivld, 1'b1);
    chk("a_itid", itid_o, 2'd1);
    chk("a_idle", idle, 1'b1);

    // D$ writes up to the outstanding limit
    for (int k = 0; k < 5; k++) begin
      tick(); dreq = 1; dwe = 1; daddr = 64'h1000 + 64'(8 * k);
      dwdata = 64'(k); dbe = 8'h0F; dtid = 2'(k);
      #2 chk("b_ack", dack, (k < 4) ? 1'b1 : 1'b0);
    end
    tick();
    #2 chk("b_held", dack, 1'b0);
    tick(); rvalid = 1; rid = 3'b110; rdata = 128'hDEAD;
    #2 chk("b_held2", dack, 1'b0);
    tick(); rvalid = 0;
    #2 chk("b_dvld", dvld, 1'b1);
    chk("b_dtid", dtid_o, 2'd2);
    chk("b_data", rdata_o, 128'hDEAD);
    chk("b_ack5", dack, 1'b1);
    tick(); dreq = 0;
    #2 chk("b_id", mid, 3'b100);
    chk("b_we", mwe, 1'b1);
    chk("b_be", mbe, 8'h0F);
    chk("b_wdata", mwdata, 64'h4);
    chk("b_addr", maddr, 64'h1020);
    for (int k = 0; k < 4; k++) begin
      tick(); rvalid = 1; rid = {1'b1, q_d[0]}; rdata = 128'(k);
    end
    tick(); rvalid = 0;

    // both requesting: strict alternation starting with I$
    for (int k = 0; k < 4; k++) begin
      tick(); ireq = 1; dreq = 1; dwe = 0; iaddr = 64'h200 + 64'(k);
      daddr = 64'h300 + 64'(k); itid = 2'(k); dtid = 2'(k); dbe = 8'hFF;
      #2 chk("c_ack_i", iack, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("c_ack_d", dack, (k % 2 == 1) ? 1'b1 : 1'b0);
    end
    tick(); ireq = 0; dreq = 0;
    tick(); ready = 0; ireq = 1; dreq = 1; iaddr = 64'hCAFE_0000; itid = 2'd3;
    #2 chk("c_first_i", iack, 1'b1);
    chk("c_first_d", dack, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      #2 chk("c_stall_i", iack, 1'b0);
      chk("c_stall_d", dack, 1'b0);
      chk("c_stall_addr", maddr, 64'hCAFE_0000);
      chk("c_stall_id", mid, 3'b011);
    end
    tick(); ready = 1;
    #2 chk("c_resume_d", dack, 1'b1);
    chk("c_resume_i", iack, 1'b0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (m_gnt_i) ireq = 0;
      if (!ireq && $urandom_range(0, 2) != 0) begin
        ireq = 1; iaddr = {$urandom, $urandom}; itid = 2'($urandom);
      end
      if (m_gnt_d) dreq = 0;
      if (!dreq && $urandom_range(0, 2) != 0) begin
        dreq = 1; daddr = {$urandom, $urandom}; dwe = 1'($urandom);
        dwdata = {$urandom, $urandom}; dbe = 8'($urandom); dtid = 2'($urandom);
      end
      ready = ($urandom_range(0, 3) != 0);
      rvalid = 0;
      if ($urandom_range(0, 2) == 0) begin
        rdata = {$urandom, $urandom, $urandom, $urandom};
        if (q_i.size() != 0 && (q_d.size() == 0 || $urandom_range(0, 1) == 0)) begin
          rvalid = 1; rid = {1'b0, q_i[$urandom_range(0, q_i.size() - 1)]};
        end else if (q_d.size() != 0) begin
          rvalid = 1; rid = {1'b1, q_d[$urandom_range(0, q_d.size() - 1)]};
        end
      end
    end

    // drain everything
    done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      tick(); ireq = 0; dreq = 0; ready = 1;
      if (q_i.size() != 0) begin
        rvalid = 1; rid = {1'b0, q_i[0]};
      end else if (q_d.size() != 0) begin
        rvalid = 1; rid = {1'b1, q_d[0]};
      end else begin
        done = !rvalid && !m_valid;
        rvalid = 0;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    #2 chk("drain_idle", idle, 1'b1);

    // stray I$ return with nothing outstanding
    tick(); rvalid = 1; rid = 3'b000; rdata = 128'h1234;
    tick(); rvalid = 0;
    #2 chk("s_ivld", ivld, 1'b1);
    chk("s_data", rdata_o, 128'h1234);
    chk("s_err", err, 1'b1);
    tick();
    #2 chk("s_err_sticky", err, 1'b1);
    chk("s_idle", idle, 1'b1);

    // async reset while a request is stalled
    tick(); ready = 0; ireq = 1; iaddr = 64'h4000; itid = 2'd2;
    #2 chk("r_ack", iack, 1'b1);
    tick(); ireq = 0;
    #2 chk("r_full", mvalid, 1'b1);
    #1 rst_n = 0;
    #1 chk("r_valid_async", mvalid, 1'b0);
    chk("r_idle_async", idle, 1'b1);
    chk("r_err_async", err, 1'b0);
    tick(); tick(); rst_n = 1; ready = 1;
    #2 chk("r_valid", mvalid, 1'b0);
    chk("r_idle", idle, 1'b1);
    tick(); ireq = 1; iaddr = 64'h4400; itid = 2'd3;
    #2 chk("r_ack2", iack, 1'b1);
    tick(); ireq = 0;
    #2 chk("r_id2", mid, 3'b011);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
